reg_scoreboard: RTL and testbench

//  Producer-side companion to the forwarding/stall logic. Tracks GPR writes that are still
//   in flight from ID-issue to WB-commit: one pending counter per register.

---
 rtl/reg_scoreboard_pkg.sv | 7 +
 rtl/reg_scoreboard_counter.sv | 29 ++
 rtl/reg_scoreboard.sv | 85 ++++++++
 tb/tb_reg_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing constants for the GPR write scoreboard.
package reg_scoreboard_pkg;
   localparam int SB_NR_REGS   = 32;
   localparam int SB_CNT_W     = 2;
   localparam int REG_IDX_W    = 5;
   localparam logic [REG_IDX_W-1:0] X0_IDX = '0;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// Pending-write counter for one GPR: +inc, -dec (0..2), clamps at zero on underflow.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [1:0]       dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             underflow
);
   logic [CNT_W:0] sum;

   assign sum       = {1'b0, cnt} + (CNT_W+1)'(inc);
   // A flush discards everything in flight, so it can never count as an underflow.
   assign underflow = ~clr & ((CNT_W+1)'(dec) > sum);
   assign busy      = |cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || underflow)
         cnt <= '0;
      else
         cnt <= CNT_W'(sum - (CNT_W+1)'(dec));
   end
endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight GPR writes (ID issue to WB commit) and raises id_stall on RAW or WAW saturation.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NR_REGS   = SB_NR_REGS,
   parameter int CNT_W     = SB_CNT_W,
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_rd_w_en,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 issue_fire,
   input  logic                 wb_rd_w_en,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic                 kill_valid,
   input  logic [REG_IDX_W-1:0] kill_rd,
   input  logic                 flush_all,
   output logic                 id_stall,
   output logic [NR_REGS-1:0]   busy_vec,
   output logic                 pending_any,
   output logic                 err_underflow
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]   cnt [NR_REGS];
   logic [NR_REGS-1:0] uf_vec;
   logic               fire;
   logic [CNT_W-1:0]   c_rs1, c_rs2;
   logic               raw1, raw2, sat;

   // An issue attempted while stalled is a protocol violation and is dropped.
   assign fire = issue_fire & id_valid & ~id_stall;

   assign cnt[0]      = '0;
   assign busy_vec[0] = 1'b0;
   assign uf_vec[0]   = 1'b0;

   for (genvar g = 1; g < NR_REGS; g++) begin : g_cnt
      logic       inc;
      logic [1:0] dec;

      assign inc = fire & id_rd_w_en & (id_rd == REG_IDX_W'(g));
      assign dec = 2'(wb_rd_w_en & (wb_rd == REG_IDX_W'(g)))
                 + 2'(kill_valid & (kill_rd == REG_IDX_W'(g)));

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc),
         .dec       (dec),
         .clr       (flush_all),
         .cnt       (cnt[g]),
         .busy      (busy_vec[g]),
         .underflow (uf_vec[g])
      );
   end

   assign pending_any = |busy_vec;

   always_comb begin
      c_rs1 = cnt[id_rs1];
      c_rs2 = cnt[id_rs2];
      // Last pending write retiring this cycle is visible through the WB bypass.
      raw1  = id_use_rs1 && (id_rs1 != X0_IDX) && (c_rs1 != '0)
              && !(WB_BYPASS && (c_rs1 == CNT_ONE) && wb_rd_w_en && (wb_rd == id_rs1));
      raw2  = id_use_rs2 && (id_rs2 != X0_IDX) && (c_rs2 != '0)
              && !(WB_BYPASS && (c_rs2 == CNT_ONE) && wb_rd_w_en && (wb_rd == id_rs2));
      sat   = id_rd_w_en && (id_rd != X0_IDX) && (cnt[id_rd] == CNT_MAX);
      id_stall = id_valid && !flush_all && (raw1 || raw2 || sat);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_underflow <= 1'b0;
      else if (|uf_vec)
         err_underflow <= 1'b1;
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (NR_REGS=32, CNT_W=2, WB_BYPASS=1).
module tb_reg_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_use_rs1, id_use_rs2;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd, kill_rd;
   logic        id_rd_w_en, issue_fire, wb_rd_w_en, kill_valid, flush_all;
   logic        id_stall, pending_any, err_underflow;
   logic [31:0] busy_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd_w_en    (id_rd_w_en),
      .id_rd         (id_rd),
      .issue_fire    (issue_fire),
      .wb_rd_w_en    (wb_rd_w_en),
      .wb_rd         (wb_rd),
      .kill_valid    (kill_valid),
      .kill_rd       (kill_rd),
      .flush_all     (flush_all),
      .id_stall      (id_stall),
      .busy_vec      (busy_vec),
      .pending_any   (pending_any),
      .err_underflow (err_underflow)
   );

   // Handshake rule: the bench must never fire an issue into a stall.
   always @(posedge clk) begin
      if (!rst && issue_fire && id_stall) begin
         errors++;
         $error("FAIL handshake: issue_fire=1 while id_stall=1");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd_w_en = 0; id_rd = 0; issue_fire = 0;
      wb_rd_w_en = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0; flush_all = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      id_valid = 1; id_rd_w_en = 1; id_rd = rd; issue_fire = 1;
   endtask

   task automatic retire(input logic [4:0] rd);
      idle();
      wb_rd_w_en = 1; wb_rd = rd;
   endtask

   initial begin
      idle();
      rst = 1;
      #1;
      chk("rst_stall", 32'(id_stall), 32'd0);
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_pending", 32'(pending_any), 32'd0);
      chk("rst_err", 32'(err_underflow), 32'd0);
      step();
      rst = 0;

      // 1. idle reads
      id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_rs1 = 5; id_rs2 = 6;
      #1;
      chk("t1_stall", 32'(id_stall), 32'd0);
      step();
      chk("t1_busy", busy_vec, 32'd0);

      // 2. load-use on x5
      issue(5);
      #1;
      chk("t2_issue_stall", 32'(id_stall), 32'd0);
      step();
      chk("t2_busy", busy_vec, 32'h0000_0020);
      chk("t2_pending", 32'(pending_any), 32'd1);
      idle();
      id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
      #1;
      chk("t2_raw_stall", 32'(id_stall), 32'd1);
      step();
      chk("t2_raw_stall_hold", 32'(id_stall), 32'd1);
      wb_rd_w_en = 1; wb_rd = 5;
      #1;
      chk("t2_bypass", 32'(id_stall), 32'd0);
      issue_fire = 1;
      step();
      chk("t2_busy_clear", busy_vec, 32'd0);
      chk("t2_pending_clear", 32'(pending_any), 32'd0);

      // 3. WAW saturation on x7
      issue(7); step();
      issue(7); step();
      issue(7);
      #1;
      chk("t3_third_ok", 32'(id_stall), 32'd0);
      step();
      issue_fire = 0;
      #1;
      chk("t3_sat_stall", 32'(id_stall), 32'd1);
      wb_rd_w_en = 1; wb_rd = 7;
      #1;
      chk("t3_sat_wb_cycle", 32'(id_stall), 32'd1);
      step();
      wb_rd_w_en = 0;
      #1;
      chk("t3_release", 32'(id_stall), 32'd0);
      retire(7); step();
      chk("t3_cnt2_busy", busy_vec, 32'h0000_0080);
      retire(7); step();
      chk("t3_cnt0_busy", busy_vec, 32'd0);
      chk("t3_no_uf", 32'(err_underflow), 32'd0);

      // 4. simultaneous issue and retire on x9
      issue(9); step();
      issue(9); wb_rd_w_en = 1; wb_rd = 9;
      #1;
      chk("t4_stall", 32'(id_stall), 32'd0);
      step();
      chk("t4_busy", busy_vec, 32'h0000_0200);
      retire(9); step();
      chk("t4_busy_clear", busy_vec, 32'd0);
      chk("t4_no_uf", 32'(err_underflow), 32'd0);

      // 5. kill then flush
      issue(3); step();
      issue(4); step();
      chk("t5_busy34", busy_vec, 32'h0000_0018);
      idle(); kill_valid = 1; kill_rd = 3; step();
      chk("t5_kill", busy_vec, 32'h0000_0010);
      issue(8); id_use_rs1 = 1; id_rs1 = 4; flush_all = 1;
      #1;
      chk("t5_flush_stall", 32'(id_stall), 32'd0);
      step();
      idle();
      #1;
      chk("t5_flush_busy", busy_vec, 32'd0);
      chk("t5_flush_pending", 32'(pending_any), 32'd0);
      chk("t5_no_uf", 32'(err_underflow), 32'd0);

      // 6. x0 and underflow
      issue(0); id_use_rs1 = 1; id_rs1 = 0;
      #1;
      chk("t6_x0_stall", 32'(id_stall), 32'd0);
      step();
      chk("t6_x0_busy", busy_vec, 32'd0);
      retire(12); step();
      idle();
      chk("t6_uf_set", 32'(err_underflow), 32'd1);
      chk("t6_uf_busy", busy_vec, 32'd0);
      step(); step();
      chk("t6_uf_sticky", 32'(err_underflow), 32'd1);
      flush_all = 1; step();
      flush_all = 0;
      chk("t6_uf_after_flush", 32'(err_underflow), 32'd1);

      // Mid-operation async reset
      issue(10); step();
      idle();
      chk("t7_busy10", busy_vec, 32'h0000_0400);
      #2 rst = 1;
      #1;
      chk("t7_rst_busy", busy_vec, 32'd0);
      chk("t7_rst_err", 32'(err_underflow), 32'd0);
      step();
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
